data_mem_responder: RTL and testbench

- Memory-side responder for load/store requests already classified upstream (load vs store, byte vs word).
- Accepts one request at a time over valid/ready and performs it against an internal byte-addressable, little-endian data array.
- After a fixed latency, returns a tagged response (load data or store ack) over a second valid/ready channel.
- Sits between the LSU issue stage and ROB writeback in the out-of-order core.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/byte_lane_mem.sv | 39 +++
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_WORD  = 3'b010;

    // Upper bound on the carried ROB tag; narrower tags are zero-extended.
    localparam int MAX_TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 is_load;
        logic                 is_store;
        logic                 is_byte;
        logic                 is_word;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [MAX_TAG_W-1:0] tag;
    } req_t;

    // Exactly one of load/store and exactly one of byte/word must be set.
    function automatic logic is_malformed(input req_t r);
        return (r.is_load == r.is_store) || (r.is_byte == r.is_word);
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_mem.sv
// ============================================================================
// Module   : byte_lane_mem
// Brief    : DEPTH x 32 array, four byte lanes, byte write enable, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_mem #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        // Read returns the pre-write contents; only load data is ever consumed.
        always_ff @(posedge clk) begin
            if (i_en) begin
                if (i_we[g]) begin
                    r_mem[i_idx] <= i_wdata[8*g +: 8];
                end
                r_q <= r_mem[i_idx];
            end
        end

        assign o_rdata[8*g +: 8] = r_q;
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding load/store responder with fixed latency and tagged response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_load,
    input  logic             req_is_store,
    input  logic             req_is_byte,
    input  logic             req_is_word,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_is_store,
    output logic             resp_err
);

    localparam int               c_idx_w    = $clog2(DEPTH);
    localparam int               c_cnt_w    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    localparam bit               c_lat1     = (LATENCY == 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    req_t                 r_req;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [TAG_W-1:0]     r_resp_tag;
    logic                 r_resp_is_store;
    logic                 r_resp_err;
    logic                 r_resp_load;
    logic                 r_resp_byte;
    logic [1:0]           r_resp_lane;

    req_t                 w_in;
    req_t                 w_cur;
    logic                 w_accept;
    logic                 w_exec;
    logic                 w_malformed;
    logic                 w_err;
    logic [3:0]           w_we;
    logic [31:0]          w_mem_wdata;
    logic [31:0]          w_rdata;
    logic [7:0]           w_lane_byte;
    logic                 w_unused;

    always_comb begin
        w_in          = '0;
        w_in.is_load  = req_is_load;
        w_in.is_store = req_is_store;
        w_in.is_byte  = req_is_byte;
        w_in.is_word  = req_is_word;
        w_in.addr     = req_addr;
        w_in.wdata    = req_wdata;
        w_in.tag      = MAX_TAG_W'(req_tag);
    end

    assign w_accept = (r_state == IDLE) && req_valid && r_req_ready;

    // With LATENCY==1 the access executes on the accept edge from live inputs.
    assign w_exec = (c_lat1 && w_accept) || ((r_state == BUSY) && (r_cnt == c_cnt_w'(1)));
    assign w_cur  = (r_state == IDLE) ? w_in : r_req;

    assign w_malformed = is_malformed(w_cur);
    assign w_err       = w_malformed || (w_cur.is_word && (w_cur.addr[1:0] != 2'b00));

    always_comb begin
        w_we = 4'b0000;
        if (w_exec && !w_err && w_cur.is_store) begin
            w_we = w_cur.is_word ? 4'b1111 : (4'b0001 << w_cur.addr[1:0]);
        end
    end

    assign w_mem_wdata = w_cur.is_word ? w_cur.wdata : {4{w_cur.wdata[7:0]}};
    assign w_unused    = ^{w_cur.addr[31:c_idx_w+2], w_cur.tag};

    byte_lane_mem #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_mem (
        .clk     (clk),
        .i_en    (w_exec),
        .i_we    (w_we),
        .i_idx   (w_cur.addr[c_idx_w+1:2]),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_req           <= '0;
            r_req_ready     <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_tag      <= '0;
            r_resp_is_store <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_load     <= 1'b0;
            r_resp_byte     <= 1'b0;
            r_resp_lane     <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req       <= w_in;
                        r_cnt       <= c_cnt_load;
                        r_req_ready <= 1'b0;
                        r_state     <= c_lat1 ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_exec) begin
                r_resp_valid    <= 1'b1;
                r_resp_tag      <= w_cur.tag[TAG_W-1:0];
                r_resp_is_store <= w_cur.is_store && !w_malformed;
                r_resp_err      <= w_err;
                r_resp_load     <= w_cur.is_load && !w_err;
                r_resp_byte     <= w_cur.is_byte;
                r_resp_lane     <= w_cur.addr[1:0];
            end
        end
    end

    // Load data is formatted from the memory's read register, which is only
    // refreshed on the execute edge and therefore stays stable in RESP.
    always_comb begin
        w_lane_byte = w_rdata[8*r_resp_lane +: 8];
        resp_data   = 32'h0;
        if (r_resp_load) begin
            resp_data = r_resp_byte ? {{24{w_lane_byte[7]}}, w_lane_byte} : w_rdata;
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_tag      = r_resp_tag;
    assign resp_is_store = r_resp_is_store;
    assign resp_err      = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Randomized bench for data_mem_responder against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_is_load;
    logic             req_is_store;
    logic             req_is_byte;
    logic             req_is_word;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_is_store;
    logic             resp_err;

    int checks   = 0;
    int failures = 0;

    // Reference: flat little-endian byte array, DEPTH*4 bytes, addresses wrap.
    logic [7:0] model [DEPTH*4];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_load   (req_is_load),
        .req_is_store  (req_is_store),
        .req_is_byte   (req_is_byte),
        .req_is_word   (req_is_word),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_is_store (resp_is_store),
        .resp_err      (resp_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic ld, input logic st, input logic b, input logic w,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [TAG_W-1:0] tag, input int hold,
                          output logic [31:0] got);
        logic        malf;
        logic        e_err;
        logic        e_st;
        logic [31:0] e_data;
        logic [7:0]  e_byte;
        int          a;
        int          base;
        int          n;

        malf   = (ld == st) || (b == w);
        e_err  = malf || (w && (addr[1:0] != 2'b00));
        e_st   = st && !malf;
        a      = int'(addr[31:0] & 32'(DEPTH*4-1));
        base   = a & ~3;
        e_byte = model[a];
        if (e_err || st)
            e_data = 32'h0;
        else if (w)
            e_data = {model[base+3], model[base+2], model[base+1], model[base]};
        else
            e_data = {{24{e_byte[7]}}, e_byte};
        got = 32'h0;

        @(negedge clk);
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_is_byte  = b;
        req_is_word  = w;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tag;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble request fields after acceptance; the DUT must ignore them.
        req_valid    = 1'b0;
        req_is_load  = 1'($urandom_range(0, 1));
        req_is_store = 1'($urandom_range(0, 1));
        req_is_byte  = 1'($urandom_range(0, 1));
        req_is_word  = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_tag      = TAG_W'($urandom);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check("latency", 32'(n), 32'(LATENCY));
        check("req_ready_busy", 32'(req_ready), 32'h0);
        check("resp_data", resp_data, e_data);
        check("resp_tag", 32'(resp_tag), 32'(tag));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_is_store", 32'(resp_is_store), 32'(e_st));
        got = resp_data;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_data", resp_data, e_data);
            check("hold_ctl", 32'({resp_valid, req_ready, resp_err, resp_is_store, resp_tag}),
                  32'({1'b1, 1'b0, e_err, e_st, tag}));
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_handshake", 32'({resp_valid, req_ready}), 32'h1);

        if (e_st && !e_err) begin
            if (w) begin
                for (int k = 0; k < 4; k++) model[base+k] = wdata[8*k +: 8];
            end else begin
                model[a] = wdata[7:0];
            end
        end
    endtask

    logic [31:0] d;
    logic        ld, st, b, w;
    logic [31:0] addr;
    int          r;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_is_byte  = 1'b0;
        req_is_word  = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_tag", 32'(resp_tag), 32'h0);
        check("rst_resp_is_store", 32'(resp_is_store), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        reset = 1'b0;

        // Fill the whole array so every later load has a known expectation.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 1'b1, 1'b0, 1'b1, 32'(i*4), $urandom, TAG_W'(i), 0, d);
        end

        do_req(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd3, 0, d);
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd4, 0, d);
        check("lw_deadbeef", d, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 32'h80, 5'd5, 0, d);
        do_req(1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 5'd6, 0, d);
        check("lb_sext", d, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd7, 0, d);
        check("lw_after_sb", d, 32'hDEAD80EF);

        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h12, 32'h0, 5'd8, 0, d);
        do_req(1'b0, 1'b1, 1'b0, 1'b1, 32'h12, 32'h55555555, 5'd9, 0, d);
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd10, 5, d);
        check("lw_unchanged", d, 32'hDEAD80EF);

        do_req(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 5'd11, 0, d);
        do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h5A5A5A5A, 5'd12, 0, d);
        do_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 5'd13, 0, d);
        do_req(1'b0, 1'b1, 1'b1, 1'b1, 32'h21, 32'h77, 5'd14, 0, d);
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 5'd15, 0, d);

        do_req(1'b0, 1'b1, 1'b0, 1'b1, 32'(DEPTH*4+8), 32'hCAFEF00D, 5'd16, 0, d);
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 5'd17, 0, d);
        check("wrap_alias", d, 32'hCAFEF00D);

        // Reset while an SW sits in BUSY: no response and no write.
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_load  = 1'b0;
        req_is_store = 1'b1;
        req_is_byte  = 1'b0;
        req_is_word  = 1'b1;
        req_addr     = 32'h8;
        req_wdata    = 32'h11111111;
        req_tag      = 5'd18;
        check("pre_reset_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_resp", 32'(resp_valid), 32'h0);
        end
        do_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 5'd19, 0, d);
        check("postrst_old_data", d, 32'hCAFEF00D);

        for (int k = 0; k < 200; k++) begin
            r    = int'($urandom_range(0, 15));
            ld   = 1'($urandom_range(0, 1));
            st   = !ld;
            b    = 1'($urandom_range(0, 1));
            w    = !b;
            if (r == 0) begin
                ld = 1'($urandom_range(0, 1));
                st = 1'($urandom_range(0, 1));
            end
            if (r == 1) begin
                b = 1'($urandom_range(0, 1));
                w = 1'($urandom_range(0, 1));
            end
            addr = $urandom_range(0, DEPTH*8-1);
            if (w && r != 2) addr[1:0] = 2'b00;
            do_req(ld, st, b, w, addr, $urandom, TAG_W'($urandom), int'($urandom_range(0, 3)), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
